iob_eth_axi_ram_resp: RTL and testbench

AXI4 slave memory responder that answers the burst reads and writes issued by the Ethernet core's DMA master port. It holds a word-addressed RAM and completes INCR bursts of arbitrary length on independent read and write channels. It is the system-side endpoint for DMA frame transfers in simulation and on FPGA, and it can optionally inject pseudo-random back-pressure.

---
 rtl/iob_eth_axi_ram_resp.sv | 234 +++++++++++++++++++++++
 tb/tb_iob_eth_axi_ram_resp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_axi_ram_resp.sv
// rtl/iob_eth_axi_ram_resp.sv - AXI4 slave RAM responder for the Ethernet DMA master
// Optional pseudo-random back-pressure: define IOB_ETH_AXI_STALL_EN.
module iob_eth_axi_ram_resp #(
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_DATA_W = 32,
   parameter int AXI_ID_W   = 1,
   parameter int MEM_ADDR_W = 12
) (
   input  logic                    clk,
   input  logic                    rst_int,
   input  logic [AXI_ID_W-1:0]     s_axi_awid_i,
   input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr_i,
   input  logic [7:0]              s_axi_awlen_i,
   input  logic [2:0]              s_axi_awsize_i,
   input  logic [1:0]              s_axi_awburst_i,
   input  logic                    s_axi_awlock_i,
   input  logic [3:0]              s_axi_awcache_i,
   input  logic [2:0]              s_axi_awprot_i,
   input  logic [3:0]              s_axi_awqos_i,
   input  logic                    s_axi_awvalid_i,
   output logic                    s_axi_awready_o,
   input  logic [AXI_DATA_W-1:0]   s_axi_wdata_i,
   input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb_i,
   input  logic                    s_axi_wlast_i,
   input  logic                    s_axi_wvalid_i,
   output logic                    s_axi_wready_o,
   output logic [AXI_ID_W-1:0]     s_axi_bid_o,
   output logic [1:0]              s_axi_bresp_o,
   output logic                    s_axi_bvalid_o,
   input  logic                    s_axi_bready_i,
   input  logic [AXI_ID_W-1:0]     s_axi_arid_i,
   input  logic [AXI_ADDR_W-1:0]   s_axi_araddr_i,
   input  logic [7:0]              s_axi_arlen_i,
   input  logic [2:0]              s_axi_arsize_i,
   input  logic [1:0]              s_axi_arburst_i,
   input  logic                    s_axi_arlock_i,
   input  logic [3:0]              s_axi_arcache_i,
   input  logic [2:0]              s_axi_arprot_i,
   input  logic [3:0]              s_axi_arqos_i,
   input  logic                    s_axi_arvalid_i,
   output logic                    s_axi_arready_o,
   output logic [AXI_ID_W-1:0]     s_axi_rid_o,
   output logic [AXI_DATA_W-1:0]   s_axi_rdata_o,
   output logic [1:0]              s_axi_rresp_o,
   output logic                    s_axi_rlast_o,
   output logic                    s_axi_rvalid_o,
   input  logic                    s_axi_rready_i
);

   localparam int B  = (AXI_DATA_W == 64) ? 3 : 2;
   localparam int NB = AXI_DATA_W / 8;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   logic [AXI_DATA_W-1:0] mem [0:(2**MEM_ADDR_W)-1];

   logic                  en_q;
   logic [1:0]            w_state_q, w_state_d;
   logic [AXI_ID_W-1:0]   w_id_q, w_id_d;
   logic [MEM_ADDR_W-1:0] w_idx_q, w_idx_d;
   logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic                  w_fixed_q, w_fixed_d, w_err_q, w_err_d;
   logic [0:0]            r_state_q, r_state_d;
   logic [AXI_ID_W-1:0]   r_id_q, r_id_d;
   logic [MEM_ADDR_W-1:0] r_idx_q, r_idx_d, r_idx_next;
   logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic                  r_fixed_q, r_fixed_d;
   logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
   logic                  stall, aw_hs, w_hs, ar_hs, r_hs, w_last_beat;
   logic [MEM_ADDR_W-1:0] aw_idx, ar_idx;

`ifdef IOB_ETH_AXI_STALL_EN
   logic [7:0] lfsr_q;
   logic       rv_hold_q;

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         lfsr_q    <= 8'hA5;
         rv_hold_q <= 1'b0;
      end else begin
         lfsr_q    <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
         rv_hold_q <= s_axi_rvalid_o & ~(s_axi_rready_i & s_axi_rlast_o);
      end
   end

   // A stall may only delay the rise of rvalid, never retract it.
   assign stall          = lfsr_q[0];
   assign s_axi_rvalid_o = (r_state_q == R_DATA) & (rv_hold_q | ~stall);
`else
   assign stall          = 1'b0;
   assign s_axi_rvalid_o = (r_state_q == R_DATA);
`endif

   assign s_axi_awready_o = en_q & ~stall & (w_state_q == W_IDLE);
   assign s_axi_wready_o  = ~stall & (w_state_q == W_DATA);
   assign s_axi_bvalid_o  = (w_state_q == W_RESP);
   assign s_axi_bid_o     = w_id_q;
   assign s_axi_bresp_o   = {w_err_q & s_axi_bvalid_o, 1'b0};
   assign s_axi_arready_o = en_q & ~stall & (r_state_q == R_IDLE);
   assign s_axi_rid_o     = r_id_q;
   assign s_axi_rdata_o   = rdata_q;
   assign s_axi_rresp_o   = 2'b00;
   assign s_axi_rlast_o   = (r_state_q == R_DATA) & (r_cnt_q == r_len_q);

   assign aw_hs       = s_axi_awvalid_i & s_axi_awready_o;
   assign w_hs        = s_axi_wvalid_i & s_axi_wready_o;
   assign ar_hs       = s_axi_arvalid_i & s_axi_arready_o;
   assign r_hs        = s_axi_rvalid_o & s_axi_rready_i;
   assign w_last_beat = (w_cnt_q == w_len_q);
   assign aw_idx      = s_axi_awaddr_i[MEM_ADDR_W+B-1:B];
   assign ar_idx      = s_axi_araddr_i[MEM_ADDR_W+B-1:B];
   assign r_idx_next  = r_fixed_q ? r_idx_q : r_idx_q + 1'b1;

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_idx_d   = w_idx_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_fixed_d = w_fixed_q;
      w_err_d   = w_err_q;
      case (w_state_q)
         W_IDLE: if (aw_hs) begin
            w_id_d    = s_axi_awid_i;
            w_idx_d   = aw_idx;
            w_len_d   = s_axi_awlen_i;
            w_fixed_d = (s_axi_awburst_i == 2'b00);
            w_cnt_d   = 8'd0;
            w_err_d   = 1'b0;
            w_state_d = W_DATA;
         end
         W_DATA: if (w_hs) begin
            w_cnt_d = w_cnt_q + 8'd1;
            if (!w_fixed_q) w_idx_d = w_idx_q + 1'b1;
            // Length comes from awlen; wlast is only checked for consistency.
            if (w_last_beat) begin
               w_err_d   = w_err_q | ~s_axi_wlast_i;
               w_state_d = W_RESP;
            end else begin
               w_err_d = w_err_q | s_axi_wlast_i;
            end
         end
         W_RESP: if (s_axi_bready_i) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_idx_d   = r_idx_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_fixed_d = r_fixed_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: if (ar_hs) begin
            r_id_d    = s_axi_arid_i;
            r_idx_d   = ar_idx;
            r_len_d   = s_axi_arlen_i;
            r_fixed_d = (s_axi_arburst_i == 2'b00);
            r_cnt_d   = 8'd0;
            rdata_d   = mem[ar_idx];
            r_state_d = R_DATA;
         end
         R_DATA: if (r_hs) begin
            if (s_axi_rlast_o) begin
               r_state_d = R_IDLE;
            end else begin
               // Prefetch the next word so beats stream without a bubble.
               r_cnt_d = r_cnt_q + 8'd1;
               r_idx_d = r_idx_next;
               rdata_d = mem[r_idx_next];
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         en_q      <= 1'b0;
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_idx_q   <= '0;
         w_len_q   <= 8'd0;
         w_cnt_q   <= 8'd0;
         w_fixed_q <= 1'b0;
         w_err_q   <= 1'b0;
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_idx_q   <= '0;
         r_len_q   <= 8'd0;
         r_cnt_q   <= 8'd0;
         r_fixed_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         en_q      <= 1'b1;
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_idx_q   <= w_idx_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_fixed_q <= w_fixed_d;
         w_err_q   <= w_err_d;
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_idx_q   <= r_idx_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_fixed_q <= r_fixed_d;
         rdata_q   <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_hs) begin
         for (int i = 0; i < NB; i++) begin
            if (s_axi_wstrb_i[i]) mem[w_idx_q][i*8 +: 8] <= s_axi_wdata_i[i*8 +: 8];
         end
      end
   end

   logic unused_ok;
   assign unused_ok = ^{s_axi_awaddr_i, s_axi_awsize_i, s_axi_awburst_i, s_axi_awlock_i,
                        s_axi_awcache_i, s_axi_awprot_i, s_axi_awqos_i,
                        s_axi_araddr_i, s_axi_arsize_i, s_axi_arburst_i, s_axi_arlock_i,
                        s_axi_arcache_i, s_axi_arprot_i, s_axi_arqos_i};

endmodule

// File: tb/tb_iob_eth_axi_ram_resp.sv
// tb/tb_iob_eth_axi_ram_resp.sv - directed self-checking bench for iob_eth_axi_ram_resp
module tb_iob_eth_axi_ram_resp;

   logic        clk = 1'b0;
   logic        rst_int = 1'b1;
   logic [0:0]  awid = '0, arid = '0, bid, rid;
   logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
   logic [7:0]  awlen = '0, arlen = '0;
   logic [1:0]  awburst = 2'b01, arburst = 2'b01, bresp, rresp;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
   logic        awready, wready, bvalid, arready, rlast, rvalid;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   iob_eth_axi_ram_resp dut (
      .clk(clk), .rst_int(rst_int),
      .s_axi_awid_i(awid), .s_axi_awaddr_i(awaddr), .s_axi_awlen_i(awlen),
      .s_axi_awsize_i(3'd2), .s_axi_awburst_i(awburst), .s_axi_awlock_i(1'b0),
      .s_axi_awcache_i(4'd0), .s_axi_awprot_i(3'd0), .s_axi_awqos_i(4'd0),
      .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
      .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wlast_i(wlast),
      .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
      .s_axi_bid_o(bid), .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
      .s_axi_arid_i(arid), .s_axi_araddr_i(araddr), .s_axi_arlen_i(arlen),
      .s_axi_arsize_i(3'd2), .s_axi_arburst_i(arburst), .s_axi_arlock_i(1'b0),
      .s_axi_arcache_i(4'd0), .s_axi_arprot_i(3'd0), .s_axi_arqos_i(4'd0),
      .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
      .s_axi_rid_o(rid), .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp),
      .s_axi_rlast_o(rlast), .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic aw_hs(input logic [31:0] addr, input logic [7:0] len, input logic [0:0] id);
      awaddr = addr; awlen = len; awid = id; awburst = 2'b01; awvalid = 1;
      for (int c = 0; c < 20 && !awready; c++) begin @(posedge clk); #1; end
      chk("awready", awready, 1);
      @(posedge clk); #1;
      awvalid = 0;
   endtask

   task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
      wdata = d; wstrb = s; wlast = l; wvalid = 1;
      for (int c = 0; c < 20 && !wready; c++) begin @(posedge clk); #1; end
      chk("wready", wready, 1);
      @(posedge clk); #1;
      wvalid = 0;
   endtask

   task automatic b_chk(input string tag, input logic [1:0] resp, input logic [0:0] id);
      bready = 1;
      for (int c = 0; c < 20 && !bvalid; c++) begin @(posedge clk); #1; end
      chk({tag, "_bvalid"}, bvalid, 1);
      chk({tag, "_bresp"}, bresp, resp);
      chk({tag, "_bid"}, bid, id);
      @(posedge clk); #1;
      bready = 0;
   endtask

   task automatic ar_hs(input logic [31:0] addr, input logic [7:0] len, input logic [0:0] id);
      araddr = addr; arlen = len; arid = id; arburst = 2'b01; arvalid = 1;
      for (int c = 0; c < 20 && !arready; c++) begin @(posedge clk); #1; end
      chk("arready", arready, 1);
      @(posedge clk); #1;
      arvalid = 0;
      chk("rvalid_after_ar", rvalid, 1);
   endtask

   task automatic r_beat(input string tag, input logic [31:0] d, input logic l, input logic [0:0] id);
      rready = 1;
      chk({tag, "_rvalid"}, rvalid, 1);
      chk({tag, "_rdata"}, rdata, d);
      chk({tag, "_rlast"}, rlast, l);
      chk({tag, "_rid"}, rid, id);
      chk({tag, "_rresp"}, rresp, 2'b00);
      @(posedge clk); #1;
      rready = 0;
   endtask

   task automatic idle_outs(input string tag);
      chk({tag, "_awready"}, awready, 0);
      chk({tag, "_wready"}, wready, 0);
      chk({tag, "_bvalid"}, bvalid, 0);
      chk({tag, "_arready"}, arready, 0);
      chk({tag, "_rvalid"}, rvalid, 0);
      chk({tag, "_rlast"}, rlast, 0);
      chk({tag, "_rdata"}, rdata, 0);
      chk({tag, "_bresp"}, bresp, 0);
      chk({tag, "_bid"}, bid, 0);
      chk({tag, "_rid"}, rid, 0);
   endtask

   initial begin
      // Reset values and ready rise after release
      repeat (3) @(posedge clk);
      #1;
      idle_outs("rst");
      rst_int = 0;
      chk("awready_pre_edge", awready, 0);
      @(posedge clk); #1;
      chk("awready_post_rst", awready, 1);
      chk("arready_post_rst", arready, 1);

      // Single write then read
      aw_hs(32'h10, 8'd0, 1'b1);
      w_beat(32'hDEADBEEF, 4'hF, 1'b1);
      b_chk("single", 2'b00, 1'b1);
      chk("awready_after_b", awready, 1);
      ar_hs(32'h10, 8'd0, 1'b1);
      r_beat("single", 32'hDEADBEEF, 1'b1, 1'b1);
      chk("single_rvalid_end", rvalid, 0);
      chk("single_arready_end", arready, 1);

      // 16-beat INCR burst, read back with rready held high
      aw_hs(32'h100, 8'd15, 1'b0);
      for (int i = 0; i < 16; i++) w_beat(32'(i), 4'hF, i == 15);
      chk("burst_bvalid_timing", bvalid, 1);
      chk("burst_wready_off", wready, 0);
      b_chk("burst", 2'b00, 1'b0);
      ar_hs(32'h100, 8'd15, 1'b0);
      for (int i = 0; i < 16; i++) r_beat("burst", 32'(i), i == 15, 1'b0);
      chk("burst_rvalid_end", rvalid, 0);

      // Byte strobes
      aw_hs(32'h0, 8'd0, 1'b0);
      w_beat(32'h11223344, 4'hF, 1'b1);
      b_chk("strb0", 2'b00, 1'b0);
      aw_hs(32'h0, 8'd0, 1'b0);
      w_beat(32'hAABBCCDD, 4'h5, 1'b1);
      b_chk("strb1", 2'b00, 1'b0);
      ar_hs(32'h0, 8'd0, 1'b0);
      r_beat("strb", 32'h11BB33DD, 1'b1, 1'b0);

      // wlast protocol errors
      aw_hs(32'h200, 8'd3, 1'b1);
      w_beat(32'h1, 4'hF, 1'b0);
      w_beat(32'h2, 4'hF, 1'b1);
      w_beat(32'h3, 4'hF, 1'b0);
      w_beat(32'h4, 4'hF, 1'b1);
      b_chk("early_wlast", 2'b10, 1'b1);
      aw_hs(32'h300, 8'd0, 1'b0);
      w_beat(32'h5, 4'hF, 1'b0);
      b_chk("missing_wlast", 2'b10, 1'b0);
      aw_hs(32'h300, 8'd0, 1'b0);
      w_beat(32'h6, 4'hF, 1'b1);
      b_chk("err_cleared", 2'b00, 1'b0);

      // Index wrap from the last word to word 0
      aw_hs(32'h3FFC, 8'd1, 1'b0);
      w_beat(32'hCAFE0001, 4'hF, 1'b0);
      w_beat(32'hCAFE0002, 4'hF, 1'b1);
      b_chk("wrap", 2'b00, 1'b0);
      ar_hs(32'h0, 8'd0, 1'b0);
      r_beat("wrap_w0", 32'hCAFE0002, 1'b1, 1'b0);
      ar_hs(32'h3FFC, 8'd1, 1'b1);
      r_beat("wrap_r0", 32'hCAFE0001, 1'b0, 1'b1);
      r_beat("wrap_r1", 32'hCAFE0002, 1'b1, 1'b1);

      // Read back-pressure: rdata must hold while rready is low
      ar_hs(32'h100, 8'd3, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("bp_stall_rdata", rdata, 32'(i));
         @(posedge clk); #1;
         chk("bp_hold_rvalid", rvalid, 1);
         chk("bp_hold_rdata", rdata, 32'(i));
         r_beat("bp", 32'(i), i == 3, 1'b1);
      end
      chk("bp_rvalid_end", rvalid, 0);

      // Reset in the middle of a write burst
      aw_hs(32'h400, 8'd3, 1'b0);
      for (int i = 0; i < 4; i++) w_beat(32'h5A5A0000 + 32'(i), 4'hF, i == 3);
      b_chk("pre_rst", 2'b00, 1'b0);
      aw_hs(32'h400, 8'd7, 1'b1);
      w_beat(32'h77000000, 4'hF, 1'b0);
      w_beat(32'h77000001, 4'hF, 1'b0);
      rst_int = 1;
      #1;
      idle_outs("mid_rst");
      @(posedge clk); #1;
      rst_int = 0;
      chk("mid_rst_awready_pre", awready, 0);
      @(posedge clk); #1;
      chk("mid_rst_awready", awready, 1);
      chk("mid_rst_arready", arready, 1);
      ar_hs(32'h400, 8'd3, 1'b0);
      r_beat("persist0", 32'h77000000, 1'b0, 1'b0);
      r_beat("persist1", 32'h77000001, 1'b0, 1'b0);
      r_beat("untouched2", 32'h5A5A0002, 1'b0, 1'b0);
      r_beat("untouched3", 32'h5A5A0003, 1'b1, 1'b0);
      chk("final_wready", wready, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
